// File: rtl/uart_echo_pkg.sv
// uart_echo_pkg
// Shared types and constants for the UART echo block.
//   rx_state_t / tx_state_t : receiver and transmitter FSM states
//   clks_per_bit()          : system clocks per UART bit (integer division)
//   SYNC_RESET_VAL          : reset value of the rx_data synchronizer flops (line idle)
package uart_echo_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam logic SYNC_RESET_VAL = 1'b1;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a registered read port: dout holds the popped
// entry from the cycle after pop. A push while full is accepted only when
// a pop happens in the same cycle; otherwise it is ignored.
// Ports:
//   hwclk, reset : clock, asynchronous active-high reset
//   push, din    : write strobe and data
//   pop, dout    : read strobe and registered read data
//   full, empty  : occupancy flags
//   level        : current number of stored entries
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   hwclk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level == (PTR_W+1)'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop && !empty;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign wr_en = push && (!full || rd_en);

    // Storage array has no reset; its contents are meaningless until written.
    always_ff @(posedge hwclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
// UART loopback: an oversampling receiver decodes frames from rx_data,
// buffers good bytes in a sync_fifo, and a transmitter re-sends them on
// rx_trans. The last good byte is shown on leds.
// Optional feature macro: UART_ECHO_PARITY_EN adds one even-parity bit
// per frame on both RX and TX and the sticky parity_err output.
// Ports:
//   hwclk, reset : clock, asynchronous active-high reset
//   rx_data      : UART line in (idle high, asynchronous)
//   rx_trans     : UART line out (idle high, flop-driven)
//   leds         : last good byte, zero-extended
//   fifo_level   : FIFO occupancy
//   overrun      : sticky, a byte was dropped on a full FIFO
//   frame_err    : sticky, a stop bit was sampled low
//   parity_err   : sticky, parity mismatch (only with UART_ECHO_PARITY_EN)
module uart_echo_fifo
    import uart_echo_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        hwclk,
    input  logic                        reset,
    input  logic                        rx_data,
    output logic                        rx_trans,
    output logic [7:0]                  leds,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overrun,
    output logic                        frame_err
`ifdef UART_ECHO_PARITY_EN
    ,
    output logic                        parity_err
`endif
);

    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);

    logic rx_meta;
    logic rxs;

    rx_state_t            rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [3:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 push_req;
`ifdef UART_ECHO_PARITY_EN
    logic                 parity_bad;
`endif

    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [3:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_line;
`ifdef UART_ECHO_PARITY_EN
    logic                 tx_par;
`endif

    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            rx_meta <= SYNC_RESET_VAL;
            rxs     <= SYNC_RESET_VAL;
        end else begin
            rx_meta <= rx_data;
            rxs     <= rx_meta;
        end
    end

    // Receiver: half-bit wait to the start-bit centre, then one sample per
    // bit period. A good frame raises push_req for one cycle, so the FIFO
    // write and the leds update land one cycle after the stop sample.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_shreg  <= '0;
            push_req  <= 1'b0;
            leds      <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            push_req <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rxs) begin
                        rx_state <= RX_START;
                        rx_cnt   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (rxs) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= BIT_LAST;
                            rx_idx   <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shreg <= {rxs, rx_shreg[DATA_BITS-1:1]};
                        rx_cnt   <= BIT_LAST;
                        rx_idx   <= rx_idx + 1'b1;
                        if (rx_idx == LAST_BIT) begin
`ifdef UART_ECHO_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
`ifdef UART_ECHO_PARITY_EN
                RX_PARITY: begin
                    if (rx_cnt == '0) begin
                        // Even parity: data bits plus parity bit XOR to zero.
                        parity_bad <= rxs ^ (^rx_shreg);
                        rx_cnt     <= BIT_LAST;
                        rx_state   <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_cnt == '0) begin
                        rx_state <= RX_IDLE;
                        if (!rxs) begin
                            frame_err <= 1'b1;
`ifdef UART_ECHO_PARITY_EN
                        end else if (parity_bad) begin
                            parity_err <= 1'b1;
`endif
                        end else begin
                            push_req <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase

            if (push_req) begin
                leds <= 8'(rx_shreg);
            end
            if (push_req && fifo_full && !fifo_pop) begin
                overrun <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .hwclk (hwclk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (rx_shreg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Pop from idle, or on the last stop-bit cycle so queued frames follow
    // each other with no idle gap.
    assign fifo_pop = ((tx_state == TX_IDLE) ||
                       (tx_state == TX_STOP && tx_cnt == '0)) && !fifo_empty;

    // Transmitter: the start bit goes out while the FIFO read completes;
    // fifo_dout is valid by the end of the start bit and is loaded then.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
            tx_line  <= 1'b1;
`ifdef UART_ECHO_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_line <= 1'b1;
                    if (fifo_pop) begin
                        tx_state <= TX_START;
                        tx_line  <= 1'b0;
                        tx_cnt   <= BIT_LAST;
                    end
                end
                TX_START: begin
                    if (tx_cnt == '0) begin
                        tx_state <= TX_DATA;
                        tx_line  <= fifo_dout[0];
                        tx_shreg <= fifo_dout >> 1;
                        tx_idx   <= '0;
                        tx_cnt   <= BIT_LAST;
`ifdef UART_ECHO_PARITY_EN
                        tx_par   <= ^fifo_dout;
`endif
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= BIT_LAST;
                        if (tx_idx == LAST_BIT) begin
`ifdef UART_ECHO_PARITY_EN
                            tx_state <= TX_PARITY;
                            tx_line  <= tx_par;
`else
                            tx_state <= TX_STOP;
                            tx_line  <= 1'b1;
`endif
                        end else begin
                            tx_line  <= tx_shreg[0];
                            tx_shreg <= tx_shreg >> 1;
                            tx_idx   <= tx_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
`ifdef UART_ECHO_PARITY_EN
                TX_PARITY: begin
                    if (tx_cnt == '0) begin
                        tx_state <= TX_STOP;
                        tx_line  <= 1'b1;
                        tx_cnt   <= BIT_LAST;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (tx_cnt == '0) begin
                        if (fifo_pop) begin
                            tx_state <= TX_START;
                            tx_line  <= 1'b0;
                            tx_cnt   <= BIT_LAST;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_line  <= 1'b1;
                end
            endcase
        end
    end

    assign rx_trans = tx_line;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo
// Scoreboard bench for uart_echo_fifo at 12 clocks per bit, FIFO depth 4.
// Stimulus tasks push expected echo bytes into exp_q; an independent line
// monitor decodes every frame seen on rx_trans and compares against it.
// Build with UART_ECHO_PARITY_EN to include the parity scenarios.
module tb_uart_echo_fifo;

    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 1000000;
    localparam int CPB    = 12;
    localparam int DEPTH  = 4;
`ifdef UART_ECHO_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       hwclk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_data = 1'b1;
    logic       rx_trans;
    logic [7:0] leds;
    logic [2:0] fifo_level;
    logic       overrun;
    logic       frame_err;
`ifdef UART_ECHO_PARITY_EN
    logic       parity_err;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         mon_busy = 0;
    bit         allow_drop = 0;
    int         drops = 0;
    int         max_level = 0;
    int         tx_low_cnt = 0;

    uart_echo_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DATA_BITS  (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .hwclk      (hwclk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_trans   (rx_trans),
        .leds       (leds),
        .fifo_level (fifo_level),
        .overrun    (overrun),
        .frame_err  (frame_err)
`ifdef UART_ECHO_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 hwclk = ~hwclk;

    always @(negedge hwclk) begin
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (!rx_trans) tx_low_cnt = tx_low_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Drive one frame on rx_data, one bit per CPB cycles, stop bit held
    // stop_len cycles; queue the byte for echo when push_exp is set.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                 input int stop_len, input logic par_val,
                                 input bit push_exp);
        if (push_exp) exp_q.push_back(data);
        @(negedge hwclk);
        rx_data = 1'b0;
        repeat (CPB) @(negedge hwclk);
        for (int i = 0; i < 8; i++) begin
            rx_data = data[i];
            repeat (CPB) @(negedge hwclk);
        end
`ifdef UART_ECHO_PARITY_EN
        rx_data = par_val;
        repeat (CPB) @(negedge hwclk);
`else
        if (par_val) rx_data = 1'b1;
`endif
        rx_data = stop_val;
        repeat (stop_len) @(negedge hwclk);
        rx_data = 1'b1;
    endtask

    // Wait until all queued echoes have been seen and the line is quiet.
    task automatic waitEchoDone(input int budget);
        int quiet;
        bit done;
        quiet = 0;
        done  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge hwclk);
            if (!mon_busy && rx_trans && fifo_level == 0) quiet++;
            else quiet = 0;
            if (quiet >= 20 && (exp_q.size() == 0 || allow_drop)) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL echo_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    // Line monitor: every bit must hold for exactly CPB cycles.
    initial begin
        logic        prev;
        logic [10:0] bits;
        logic [7:0]  got;
        logic [7:0]  exp_b;
        bit          shape_ok;
        bit          abort;
        prev = 1'b1;
        forever begin
            @(negedge hwclk);
            if (reset) begin
                prev = 1'b1;
                continue;
            end
            if (prev && !rx_trans) begin
                mon_busy = 1;
                abort    = 0;
                shape_ok = 1;
                bits     = '0;
                for (int b = 0; b < FRAME_BITS; b++) begin
                    for (int j = 0; j < CPB; j++) begin
                        if (!(b == 0 && j == 0)) @(negedge hwclk);
                        if (reset) begin
                            abort = 1;
                            break;
                        end
                        if (j == 0) bits[b] = rx_trans;
                        else if (rx_trans !== bits[b]) shape_ok = 0;
                    end
                    if (abort) break;
                end
                if (!abort) begin
                    got = bits[8:1];
                    checkOutput("frame_shape", {31'd0, shape_ok}, 32'd1);
                    checkOutput("stop_bit", {31'd0, bits[FRAME_BITS-1]}, 32'd1);
`ifdef UART_ECHO_PARITY_EN
                    checkOutput("parity_bit", {31'd0, bits[9]}, {31'd0, ^got});
`endif
                    if (allow_drop) begin
                        while (exp_q.size() > 0 && exp_q[0] != got) begin
                            void'(exp_q.pop_front());
                            drops++;
                        end
                    end
                    if (exp_q.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("[TB] FAIL echo_unexpected actual=%0h required=none", got);
                    end else begin
                        exp_b = exp_q.pop_front();
                        checkOutput("echo_data", {24'd0, got}, {24'd0, exp_b});
                    end
                end
                mon_busy = 0;
                prev = abort ? 1'b1 : rx_trans;
            end else begin
                prev = rx_trans;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;

        // Reset state
        repeat (3) @(negedge hwclk);
        checkOutput("rst_rx_trans", {31'd0, rx_trans}, 32'd1);
        checkOutput("rst_leds", {24'd0, leds}, 32'd0);
        checkOutput("rst_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge hwclk);

        // Single good frame 0xA5 (even parity of A5 is 0)
        $display("[TB] single frame 0xA5");
        applyStimulus(8'hA5, 1'b1, CPB, 1'b0, 1);
        waitEchoDone(1000);
        checkOutput("a5_leds", {24'd0, leds}, 32'hA5);
        checkOutput("a5_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("a5_frame_err", {31'd0, frame_err}, 32'd0);

        // 5-cycle glitch is a false start
        $display("[TB] glitch");
        tx_low_cnt = 0;
        @(negedge hwclk);
        rx_data = 1'b0;
        repeat (5) @(negedge hwclk);
        rx_data = 1'b1;
        repeat (200) @(negedge hwclk);
        checkOutput("glitch_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("glitch_tx_low_cycles", tx_low_cnt, 32'd0);
        checkOutput("glitch_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("glitch_leds", {24'd0, leds}, 32'hA5);

        // Bad stop bit: frame 0x3C discarded
        $display("[TB] bad stop bit");
        tx_low_cnt = 0;
        applyStimulus(8'h3C, 1'b0, CPB, 1'b0, 0);
        repeat (200) @(negedge hwclk);
        checkOutput("stop0_frame_err", {31'd0, frame_err}, 32'd1);
        checkOutput("stop0_leds", {24'd0, leds}, 32'hA5);
        checkOutput("stop0_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("stop0_tx_low_cycles", tx_low_cnt, 32'd0);

        // 20 back-to-back frames with a short stop bit
        $display("[TB] burst 0x00..0x13");
        allow_drop = 1;
        drops = 0;
        max_level = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'(i), 1'b1, 8, ^(8'(i)), 1);
        end
        waitEchoDone(3000);
        drops = drops + exp_q.size();
        exp_q.delete();
        allow_drop = 0;
        checks = checks + 1;
        if (max_level > DEPTH) begin
            errors = errors + 1;
            $display("[TB] FAIL burst_level_max actual=%0d required<=%0d", max_level, DEPTH);
        end
        checkOutput("burst_overrun_vs_drops", {31'd0, overrun}, {31'd0, drops > 0});

        // Reset in the middle of an echoed frame
        $display("[TB] reset mid TX");
        applyStimulus(8'h11, 1'b1, CPB, 1'b0, 1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge hwclk);
            if (mon_busy) begin
                seen = 1;
                break;
            end
        end
        checkOutput("midtx_started", {31'd0, seen}, 32'd1);
        repeat (30) @(negedge hwclk);
        reset = 1'b1;
        #1;
        checkOutput("midtx_rx_trans", {31'd0, rx_trans}, 32'd1);
        checkOutput("midtx_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("midtx_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("midtx_leds", {24'd0, leds}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge hwclk);
        reset = 1'b0;
        repeat (3) @(negedge hwclk);
        applyStimulus(8'h5A, 1'b1, CPB, 1'b0, 1);
        waitEchoDone(1000);
        checkOutput("post_rst_leds", {24'd0, leds}, 32'h5A);

`ifdef UART_ECHO_PARITY_EN
        // Parity: 0x07 needs parity bit 1
        $display("[TB] parity");
        tx_low_cnt = 0;
        applyStimulus(8'h07, 1'b1, CPB, 1'b0, 0);
        repeat (200) @(negedge hwclk);
        checkOutput("par_bad_err", {31'd0, parity_err}, 32'd1);
        checkOutput("par_bad_tx_low_cycles", tx_low_cnt, 32'd0);
        checkOutput("par_bad_leds", {24'd0, leds}, 32'h5A);
        applyStimulus(8'h07, 1'b1, CPB, 1'b1, 1);
        waitEchoDone(1000);
        checkOutput("par_good_leds", {24'd0, leds}, 32'h07);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Parametrised UART loopback block: a real oversampling receiver decodes bytes from `rx_data`, buffers them in a small synchronous FIFO, and a transmitter re-sends them on `rx_trans`. It replaces the 2-flop passthrough echo on the iCE40 board top level. It also displays the last accepted byte on the LED bank. All logic runs on the board oscillator clock.

## Interface
- `CLK_HZ`, 12000000: `hwclk` frequency in Hz.
- `BAUD`, 9600: line rate. `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division); must be ≥ 4.
- `DATA_BITS`, 8: payload bits per frame, range 5..8.
- `FIFO_DEPTH`, 16: buffer entries; power of two, ≥ 2.

- `hwclk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  1  UART line in, idle high, asynchronous to `hwclk`.
- `rx_trans`  out  1  UART line out, idle high.
- `leds`  out  8  last accepted byte, zero-extended from `DATA_BITS`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a stop bit was sampled low.

## Operation
- Reset values:
  - `rx_trans`=1, `leds`=0, `fifo_level`=0, `overrun`=0, `frame_err`=0.
  - Synchronizer flops reset to 1.
  - RX and TX FSMs reset to IDLE.
- Sticky flags clear only on `reset`.
- RX input: `rx_data` passes through a 2-flop synchronizer. All RX decisions use the second flop, `rxs`.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: when `rxs`=0, go to START and load the bit counter.
  - START: wait `CLKS_PER_BIT/2` cycles, then sample. If `rxs`=1, it is a false start: return to IDLE with nothing pushed. If `rxs`=0, go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles, LSB first, for `DATA_BITS` samples.
  - STOP: sample after a further `CLKS_PER_BIT` cycles.
    - Sample = 1: push the byte and update `leds`.
    - Sample = 0: set `frame_err` and discard the byte.
    - Either way, return to IDLE.
- FIFO push when full, no pop in the same cycle: byte dropped, `overrun` set, contents unchanged.
- FIFO push when full, pop in the same cycle: push accepted, level unchanged.
- FIFO pop when empty: never issued.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: when the FIFO is not empty, pop one byte into the shift register and go to START.
  - START: drive 0.
  - DATA: drive `DATA_BITS` bits, LSB first.
  - STOP: drive 1.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles, then TX returns to IDLE.
  - Back-to-back frames have no extra idle time between them.
- RX and TX are fully independent; simultaneous push and pop is legal in any cycle.
- Reset asserted mid-frame: both FSMs abort, FIFO contents are lost, and `rx_trans` returns to 1 asynchronously.

## Timing
- Start-edge detect: 2 cycles after the `rx_data` fall.
- Start sample point: edge detect + `CLKS_PER_BIT/2`.
- Data bit n sample point: start sample + (n+1)·`CLKS_PER_BIT`.
- Push/`leds` update: registered 1 cycle after the stop-bit sample. `fifo_level` increments in that same cycle.
- TX pop: the cycle after `fifo_level` becomes non-zero.
- TX start bit: appears on `rx_trans` 1 cycle after the pop.
- Echo latency, RX line to TX line (empty FIFO, TX idle):
  - From stop-bit mid-sample to `rx_trans` falling: 3 cycles.
  - From `rx_data` start edge to `rx_trans` start edge: about (`DATA_BITS`+1.5)·`CLKS_PER_BIT` + 5 cycles.
- `rx_trans` is driven directly from a flop (glitch-free).

## Configuration
- Macro `UART_ECHO_PARITY_EN`.
- Defined:
  - Frame gains one even-parity bit between the last data bit and the stop bit, on both RX and TX.
  - RX samples the parity bit at its mid-point.
  - On a parity mismatch, the byte is discarded and an extra sticky output `parity_err` (1 bit, reset 0) is set.
  - Latencies grow by `CLKS_PER_BIT`.
- Undefined: 8N1-style framing (`DATA_BITS`, no parity, 1 stop bit). `parity_err` port is absent.

## Structure
- Package `uart_echo_pkg` holds:
  - `rx_state_t` and `tx_state_t` enums;
  - a `clks_per_bit(CLK_HZ, BAUD)` function;
  - a `SYNC_RESET_VAL` constant of 1'b1.
- One sub-module, `sync_fifo`:
  - parameters `WIDTH`, `DEPTH`;
  - ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `level`;
  - registered-output read (`dout` valid the cycle after `pop`).
- RX and TX FSMs stay inline in `uart_echo_fifo`.

## Test plan
All scenarios use `CLK_HZ`=12000000 and `BAUD`=1000000 (12 clocks per bit).
- Single frame 0xA5 on `rx_data` → `leds`=0xA5, then 0xA5 on `rx_trans` (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 12 cycles per bit, `overrun`=`frame_err`=0.
- 0.4-bit low glitch on an idle `rx_data` → no push, `fifo_level` stays 0, `rx_trans` stays 1.
- Frame 0x3C with stop bit forced 0 → `frame_err`=1, nothing echoed, `leds` unchanged.
- 20 back-to-back frames 0x00..0x13 with `FIFO_DEPTH`=4 → `overrun`=1. Echoed stream is ordered and is a subsequence of the input. `fifo_level` never exceeds 4.
- `reset` pulsed mid-way through TX data bits → `rx_trans`=1 immediately, `fifo_level`=0, next frame 0x5A echoes correctly.
- With `UART_ECHO_PARITY_EN`: frame 0x07 with a wrong parity bit → `parity_err`=1, no echo. Frame 0x07 with correct parity (1) → echo includes parity bit 1.
